// File: rtl/rv_pkg.sv
// Shared RV32 definitions for the memory access unit: funct3 codes, FSM states,
// latched request payload and request legality check.
package rv_pkg;

   localparam int unsigned XLEN   = 32;
   localparam int unsigned REG_AW = 5;
   localparam int unsigned BE_W   = XLEN / 8;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUS  = 2'd1,
      WB   = 2'd2
   } mau_state_t;

   // Request fields kept for the bus phase and load extraction.
   typedef struct packed {
      logic              we;
      logic [2:0]        funct3;
      logic [1:0]        addr_lo;
      logic [REG_AW-1:0] rd;
   } mau_req_t;

   // High when the request must be rejected without a bus access.
   function automatic logic mau_req_bad(input logic       we,
                                        input logic [2:0] funct3,
                                        input logic [1:0] addr_lo);
      logic illegal;
      logic misal;
      if (we) begin
         illegal = !(funct3 == F3_B || funct3 == F3_H || funct3 == F3_W);
      end else begin
         illegal = !(funct3 == F3_B || funct3 == F3_H || funct3 == F3_W ||
                     funct3 == F3_BU || funct3 == F3_HU);
      end
      misal = ((funct3[1:0] == 2'b01) && addr_lo[0]) ||
              ((funct3[1:0] == 2'b10) && (addr_lo != 2'b00));
      return illegal | misal;
   endfunction

endpackage

// File: rtl/mau_align.sv
// Combinational lane logic: store data replication / byte enables, and
// load byte/half extraction with sign or zero extension.
module mau_align
   import rv_pkg::*;
(
   input  logic [2:0]      st_funct3,
   input  logic [1:0]      st_addr_lo,
   input  logic [XLEN-1:0] st_wdata,
   output logic [XLEN-1:0] st_lane_c,
   output logic [BE_W-1:0] st_be_c,
   input  logic [2:0]      ld_funct3,
   input  logic [1:0]      ld_addr_lo,
   input  logic [XLEN-1:0] ld_rdata,
   output logic [XLEN-1:0] ld_data_c
);

   logic [7:0]  ld_byte;
   logic [15:0] ld_half;

   // Store lanes.
   always_comb begin
      st_lane_c = st_wdata;
      st_be_c   = 4'b1111;
      case (st_funct3)
         F3_B: begin
            st_lane_c = {4{st_wdata[7:0]}};
            st_be_c   = 4'b0001 << st_addr_lo;
         end
         F3_H: begin
            st_lane_c = {2{st_wdata[15:0]}};
            st_be_c   = st_addr_lo[1] ? 4'b1100 : 4'b0011;
         end
         default: ;
      endcase
   end

   // Load extraction.
   always_comb begin
      ld_byte   = ld_rdata[8*ld_addr_lo +: 8];
      ld_half   = ld_rdata[16*ld_addr_lo[1] +: 16];
      ld_data_c = ld_rdata;
      case (ld_funct3)
         F3_B:    ld_data_c = {{24{ld_byte[7]}}, ld_byte};
         F3_H:    ld_data_c = {{16{ld_half[15]}}, ld_half};
         F3_BU:   ld_data_c = {24'b0, ld_byte};
         F3_HU:   ld_data_c = {16'b0, ld_half};
         default: ;
      endcase
   end

endmodule

// File: rtl/mau_lsu.sv
// RV32I memory access unit: one outstanding load/store, bus req/ack handshake,
// aligned load writeback on the secondary register-file port.
module mau_lsu
   import rv_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [2:0]        req_funct3,
   input  logic [XLEN-1:0]   req_addr,
   input  logic [XLEN-1:0]   req_wdata,
   input  logic [REG_AW-1:0] req_rd,
   output logic              mem_req,
   output logic              mem_we,
   output logic [XLEN-1:0]   mem_addr,
   output logic [XLEN-1:0]   mem_wdata,
   output logic [BE_W-1:0]   mem_be,
   input  logic              mem_ack,
   input  logic [XLEN-1:0]   mem_rdata,
   output logic [REG_AW-1:0] rdmau,
   output logic              rdmau_en,
   output logic [XLEN-1:0]   data_mau_in,
   output logic              pend_valid,
   output logic [REG_AW-1:0] pend_rd,
   output logic              misalign
);

   mau_state_t        state_q, state_d;
   mau_req_t          req_q, req_d;
   logic              mem_req_q, mem_req_d;
   logic              mem_we_q, mem_we_d;
   logic [XLEN-1:0]   mem_addr_q, mem_addr_d;
   logic [XLEN-1:0]   mem_wdata_q, mem_wdata_d;
   logic [BE_W-1:0]   mem_be_q, mem_be_d;
   logic [REG_AW-1:0] rdmau_q, rdmau_d;
   logic              rdmau_en_q, rdmau_en_d;
   logic [XLEN-1:0]   data_q, data_d;
   logic              pend_valid_q, pend_valid_d;
   logic [REG_AW-1:0] pend_rd_q, pend_rd_d;
   logic              misalign_q, misalign_d;

   logic [XLEN-1:0]   st_lane_c;
   logic [BE_W-1:0]   st_be_c;
   logic [XLEN-1:0]   ld_data_c;

   mau_align u_align (
      .st_funct3  (req_funct3),
      .st_addr_lo (req_addr[1:0]),
      .st_wdata   (req_wdata),
      .st_lane_c  (st_lane_c),
      .st_be_c    (st_be_c),
      .ld_funct3  (req_q.funct3),
      .ld_addr_lo (req_q.addr_lo),
      .ld_rdata   (mem_rdata),
      .ld_data_c  (ld_data_c)
   );

   // Next-state and registered-output logic.
   always_comb begin
      state_d      = state_q;
      req_d        = req_q;
      mem_req_d    = mem_req_q;
      mem_we_d     = mem_we_q;
      mem_addr_d   = mem_addr_q;
      mem_wdata_d  = mem_wdata_q;
      mem_be_d     = mem_be_q;
      rdmau_d      = rdmau_q;
      rdmau_en_d   = 1'b0;
      data_d       = data_q;
      pend_valid_d = pend_valid_q;
      pend_rd_d    = pend_rd_q;
      misalign_d   = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (req_valid) begin
               if (mau_req_bad(req_we, req_funct3, req_addr[1:0])) begin
                  misalign_d = 1'b1;
               end else begin
                  state_d     = BUS;
                  req_d       = '{we: req_we, funct3: req_funct3,
                                  addr_lo: req_addr[1:0], rd: req_rd};
                  mem_req_d   = 1'b1;
                  mem_we_d    = req_we;
                  mem_addr_d  = {req_addr[XLEN-1:2], 2'b00};
                  mem_wdata_d = req_we ? st_lane_c : '0;
                  mem_be_d    = req_we ? st_be_c : 4'b1111;
                  if (!req_we && (req_rd != '0)) begin
                     pend_valid_d = 1'b1;
                     pend_rd_d    = req_rd;
                  end
               end
            end
         end
         BUS: begin
            if (mem_ack) begin
               mem_req_d = 1'b0;
               mem_we_d  = 1'b0;
               if (req_q.we) begin
                  state_d = IDLE;
               end else begin
                  state_d    = WB;
                  data_d     = ld_data_c;
                  rdmau_d    = req_q.rd;
                  rdmau_en_d = (req_q.rd != '0);
               end
            end
         end
         WB: begin
            state_d      = IDLE;
            pend_valid_d = 1'b0;
            pend_rd_d    = '0;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q      <= IDLE;
         req_q        <= '0;
         mem_req_q    <= 1'b0;
         mem_we_q     <= 1'b0;
         mem_addr_q   <= '0;
         mem_wdata_q  <= '0;
         mem_be_q     <= '0;
         rdmau_q      <= '0;
         rdmau_en_q   <= 1'b0;
         data_q       <= '0;
         pend_valid_q <= 1'b0;
         pend_rd_q    <= '0;
         misalign_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         req_q        <= req_d;
         mem_req_q    <= mem_req_d;
         mem_we_q     <= mem_we_d;
         mem_addr_q   <= mem_addr_d;
         mem_wdata_q  <= mem_wdata_d;
         mem_be_q     <= mem_be_d;
         rdmau_q      <= rdmau_d;
         rdmau_en_q   <= rdmau_en_d;
         data_q       <= data_d;
         pend_valid_q <= pend_valid_d;
         pend_rd_q    <= pend_rd_d;
         misalign_q   <= misalign_d;
      end
   end

   assign req_ready   = (state_q == IDLE);
   assign mem_req     = mem_req_q;
   assign mem_we      = mem_we_q;
   assign mem_addr    = mem_addr_q;
   assign mem_wdata   = mem_wdata_q;
   assign mem_be      = mem_be_q;
   assign rdmau       = rdmau_q;
   assign rdmau_en    = rdmau_en_q;
   assign data_mau_in = data_q;
   assign pend_valid  = pend_valid_q;
   assign pend_rd     = pend_rd_q;
   assign misalign    = misalign_q;

endmodule

// File: tb/tb_mau_lsu.sv
// Self-checking bench for mau_lsu: directed cases plus randomized load/store
// traffic checked against an arithmetic reference model.
module tb_mau_lsu;

   logic        clk = 1'b0;
   logic        reset;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [2:0]  req_funct3;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic [4:0]  req_rd;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_be;
   logic        mem_ack;
   logic [31:0] mem_rdata;
   logic [4:0]  rdmau;
   logic        rdmau_en;
   logic [31:0] data_mau_in;
   logic        pend_valid;
   logic [4:0]  pend_rd;
   logic        misalign;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   mau_lsu dut (
      .clk         (clk),
      .reset       (reset),
      .req_valid   (req_valid),
      .req_ready   (req_ready),
      .req_we      (req_we),
      .req_funct3  (req_funct3),
      .req_addr    (req_addr),
      .req_wdata   (req_wdata),
      .req_rd      (req_rd),
      .mem_req     (mem_req),
      .mem_we      (mem_we),
      .mem_addr    (mem_addr),
      .mem_wdata   (mem_wdata),
      .mem_be      (mem_be),
      .mem_ack     (mem_ack),
      .mem_rdata   (mem_rdata),
      .rdmau       (rdmau),
      .rdmau_en    (rdmau_en),
      .data_mau_in (data_mau_in),
      .pend_valid  (pend_valid),
      .pend_rd     (pend_rd),
      .misalign    (misalign)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Reference: access size in bytes, 0 for an illegal encoding.
   function automatic int ref_size(input logic we, input logic [2:0] f3);
      int sz;
      sz = 0;
      if (we) begin
         if (f3 <= 3'd2) sz = 1 << f3;
      end else begin
         if (f3 == 3'd0 || f3 == 3'd4) sz = 1;
         if (f3 == 3'd1 || f3 == 3'd5) sz = 2;
         if (f3 == 3'd2) sz = 4;
      end
      return sz;
   endfunction

   function automatic logic ref_reject(input logic we, input logic [2:0] f3, input logic [31:0] a);
      int sz;
      sz = ref_size(we, f3);
      return (sz == 0) || ((a % sz) != 0);
   endfunction

   function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] a,
                                            input logic [31:0] rd_word);
      int          sz;
      logic [31:0] v;
      sz = ref_size(1'b0, f3);
      v  = rd_word >> (8 * (a % 4));
      if (sz == 1) begin
         v = v & 32'hFF;
         if (f3 == 3'd0 && v >= 32'h80) v = v | 32'hFFFF_FF00;
      end else if (sz == 2) begin
         v = v & 32'hFFFF;
         if (f3 == 3'd1 && v >= 32'h8000) v = v | 32'hFFFF_0000;
      end
      return v;
   endfunction

   function automatic logic [31:0] ref_swdata(input logic [2:0] f3, input logic [31:0] d);
      if (f3 == 3'd0) return (d & 32'hFF) * 32'h0101_0101;
      if (f3 == 3'd1) return (d & 32'hFFFF) * 32'h0001_0001;
      return d;
   endfunction

   function automatic logic [31:0] ref_be(input logic we, input logic [2:0] f3, input logic [31:0] a);
      int sz;
      if (!we) return 32'hF;
      sz = ref_size(1'b1, f3);
      return 32'(((1 << sz) - 1) << (a % 4));
   endfunction

   // One complete request with the bus answering after wait_cyc idle cycles.
   task automatic do_op(input logic we, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd, input logic [4:0] rd, input int wait_cyc,
                        input logic [31:0] rword, input logic poke);
      logic wb;
      @(negedge clk);
      chk("ready_idle", 32'(req_ready), 32'd1);
      req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = a;
      req_wdata = wd; req_rd = rd;
      @(negedge clk);
      req_valid = 1'b0;
      if (ref_reject(we, f3, a)) begin
         chk("misalign_pulse", 32'(misalign), 32'd1);
         chk("rej_no_req", 32'(mem_req), 32'd0);
         chk("rej_ready", 32'(req_ready), 32'd1);
         @(negedge clk);
         chk("misalign_clear", 32'(misalign), 32'd0);
         chk("rej_no_req2", 32'(mem_req), 32'd0);
         return;
      end
      wb = !we && (rd != 5'd0);
      chk("misalign_low", 32'(misalign), 32'd0);
      chk("mem_req", 32'(mem_req), 32'd1);
      chk("mem_we", 32'(mem_we), 32'(we));
      chk("mem_addr", mem_addr, a & 32'hFFFF_FFFC);
      chk("mem_be", 32'(mem_be), ref_be(we, f3, a));
      if (we) chk("mem_wdata", mem_wdata, ref_swdata(f3, wd));
      chk("req_ready_busy", 32'(req_ready), 32'd0);
      chk("pend_valid", 32'(pend_valid), 32'(wb));
      chk("pend_rd", 32'(pend_rd), wb ? 32'(rd) : 32'd0);
      for (int i = 0; i < wait_cyc; i++) begin
         if (poke) begin
            req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'd2;
            req_addr = 32'h40; req_rd = 5'd9;
         end
         @(negedge clk);
         chk("req_held", 32'(mem_req), 32'd1);
         chk("addr_held", mem_addr, a & 32'hFFFF_FFFC);
         chk("no_early_wb", 32'(rdmau_en), 32'd0);
      end
      mem_ack = 1'b1; mem_rdata = rword;
      @(negedge clk);
      mem_ack = 1'b0; req_valid = 1'b0;
      chk("req_drop", 32'(mem_req), 32'd0);
      if (we) begin
         chk("st_ready", 32'(req_ready), 32'd1);
         chk("st_no_wb", 32'(rdmau_en), 32'd0);
      end else begin
         chk("ld_wb_en", 32'(rdmau_en), 32'(wb));
         if (wb) begin
            chk("ld_rd", 32'(rdmau), 32'(rd));
            chk("ld_data", data_mau_in, ref_load(f3, a, rword));
         end
         chk("ld_pend_wb", 32'(pend_valid), 32'(wb));
         chk("ld_ready_wb", 32'(req_ready), 32'd0);
         @(negedge clk);
         chk("ld_ready", 32'(req_ready), 32'd1);
         chk("wb_once", 32'(rdmau_en), 32'd0);
         chk("pend_clear", 32'(pend_valid), 32'd0);
         chk("pend_rd_clear", 32'(pend_rd), 32'd0);
      end
      chk("no_stray_req", 32'(mem_req), 32'd0);
   endtask

   initial begin
      reset = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'd0;
      req_addr = '0; req_wdata = '0; req_rd = '0; mem_ack = 1'b0; mem_rdata = '0;
      #12;
      chk("rst_mem_req", 32'(mem_req), 32'd0);
      chk("rst_mem_addr", mem_addr, 32'd0);
      chk("rst_mem_be", 32'(mem_be), 32'd0);
      chk("rst_rdmau_en", 32'(rdmau_en), 32'd0);
      chk("rst_data", data_mau_in, 32'd0);
      chk("rst_pend", 32'(pend_valid), 32'd0);
      chk("rst_misalign", 32'(misalign), 32'd0);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      chk("rst_ready", 32'(req_ready), 32'd1);

      // Directed cases.
      do_op(1'b0, 3'd2, 32'h100, 32'h0, 5'd5, 2, 32'hDEAD_BEEF, 1'b0);
      chk("lw_data", data_mau_in, 32'hDEAD_BEEF);
      do_op(1'b0, 3'd0, 32'h103, 32'h0, 5'd6, 1, 32'h8011_2233, 1'b0);
      chk("lb_data", data_mau_in, 32'hFFFF_FF80);
      do_op(1'b0, 3'd4, 32'h103, 32'h0, 5'd6, 0, 32'h8011_2233, 1'b0);
      chk("lbu_data", data_mau_in, 32'h0000_0080);
      do_op(1'b0, 3'd1, 32'h102, 32'h0, 5'd7, 0, 32'h8011_2233, 1'b0);
      chk("lh_data", data_mau_in, 32'hFFFF_8011);
      do_op(1'b1, 3'd1, 32'h22, 32'h0000_ABCD, 5'd3, 1, 32'h0, 1'b1);
      do_op(1'b0, 3'd2, 32'h102, 32'h0, 5'd5, 0, 32'h0, 1'b0);
      do_op(1'b0, 3'd7, 32'h100, 32'h0, 5'd5, 0, 32'h0, 1'b0);
      do_op(1'b1, 3'd4, 32'h100, 32'h0, 5'd5, 0, 32'h0, 1'b0);
      do_op(1'b0, 3'd2, 32'h200, 32'h0, 5'd0, 0, 32'h1234_5678, 1'b0);

      // Reset while the bus request is outstanding.
      @(negedge clk);
      req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'd2; req_addr = 32'h300; req_rd = 5'd4;
      @(negedge clk);
      req_valid = 1'b0;
      chk("pre_rst_req", 32'(mem_req), 32'd1);
      #2 reset = 1'b0;
      #1;
      chk("async_req_drop", 32'(mem_req), 32'd0);
      chk("async_pend_drop", 32'(pend_valid), 32'd0);
      chk("async_ready", 32'(req_ready), 32'd1);
      @(negedge clk);
      reset = 1'b1;
      mem_ack = 1'b1; mem_rdata = 32'hCAFE_F00D;
      @(negedge clk);
      mem_ack = 1'b0;
      chk("late_ack_no_wb", 32'(rdmau_en), 32'd0);
      chk("late_ack_ready", 32'(req_ready), 32'd1);
      chk("late_ack_no_req", 32'(mem_req), 32'd0);
      @(negedge clk);
      chk("late_ack_no_wb2", 32'(rdmau_en), 32'd0);

      // Randomized traffic.
      for (int n = 0; n < 300; n++) begin
         logic        r_we;
         logic [2:0]  r_f3;
         logic [31:0] r_a;
         logic [4:0]  r_rd;
         r_we = 1'($urandom_range(0, 1));
         r_f3 = 3'($urandom_range(0, 7));
         if ($urandom_range(0, 3) != 0) r_f3 = r_we ? 3'($urandom_range(0, 2))
                                                    : 3'($urandom_range(0, 2) == 0 ? 4 : $urandom_range(0, 2));
         r_a  = $urandom;
         if ($urandom_range(0, 2) != 0) r_a = r_a & ~(32'((1 << ref_size(r_we, r_f3)) - 1) & 32'h3);
         r_rd = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
         do_op(r_we, r_f3, r_a, $urandom, r_rd, $urandom_range(0, 3), $urandom,
               1'($urandom_range(0, 1)));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/mau_lsu.md
# mau_lsu

Memory access unit for the RV32I core. It accepts one load/store request at a time from the execute stage and runs the data-bus request/acknowledge handshake. Load results are aligned and sign/zero-extended, then written back through the register file's secondary write port (`rdmau`, `rdmau_en`, `data_mau_in`). The block also publishes the pending load destination so the hazard logic can stall dependent instructions.

## Interface
Parameters: none. All widths are fixed at RV32: 32-bit data/address, 5-bit register index.

- `clk` in 1: clock
- `reset` in 1: reset, asynchronous, active-low
- `req_valid` in 1: execute stage presents a memory op
- `req_ready` out 1: high only in IDLE; request accepted when `req_valid & req_ready`
- `req_we` in 1: 1 = store, 0 = load
- `req_funct3` in 3: RV32I funct3 (LB/LH/LW/LBU/LHU, SB/SH/SW)
- `req_addr` in 32: byte address
- `req_wdata` in 32: store data (rs2)
- `req_rd` in 5: load destination
- `mem_req` out 1: bus request, held until acknowledged
- `mem_we` out 1: bus write
- `mem_addr` out 32: word-aligned address (`req_addr & ~3`)
- `mem_wdata` out 32: lane-replicated store data
- `mem_be` out 4: byte enables
- `mem_ack` in 1: bus acknowledge, sampled on `clk`
- `mem_rdata` in 32: read word, valid when `mem_ack`
- `rdmau` out 5: writeback register index
- `rdmau_en` out 1: one-cycle writeback strobe
- `data_mau_in` out 32: writeback data
- `pend_valid` out 1: a load to a nonzero `rd` is in flight
- `pend_rd` out 5: its destination
- `misalign` out 1: one-cycle pulse on a misaligned or illegal request

## Operation
- FSM states: IDLE, BUS, WB.
- IDLE, on an accepted request:
  - illegal funct3 or misaligned address: no bus access; `misalign`=1 for the next cycle; stay IDLE.
  - otherwise: latch the request and go to BUS.
- Illegal funct3: load 011, 110, 111; store with funct3[2]=1 or 011.
- Misaligned: halfword with addr[0]=1; word with addr[1:0]≠0.
- BUS: `mem_req`=1, with `mem_we`/`mem_addr`/`mem_wdata`/`mem_be` registered and stable until `mem_ack`.
  - on `mem_ack`, store: go to IDLE.
  - on `mem_ack`, load: register the extracted data and go to WB.
- WB: `rdmau_en`=1 only if latched rd≠0; then go to IDLE. A load to x0 still performs the bus access.
- Store lanes:
  - SB: `mem_wdata`={4{wdata[7:0]}}, `mem_be`=0001<<addr[1:0].
  - SH: `mem_wdata`={2{wdata[15:0]}}, `mem_be`=addr[1]?1100:0011.
  - SW: `mem_wdata`=wdata, `mem_be`=1111.
- Loads always drive `mem_be`=1111.
- Load extract:
  - byte = `mem_rdata`[8*addr[1:0] +: 8]; half = `mem_rdata`[16*addr[1] +: 16].
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes through.
- `pend_valid`: high from the cycle after accepting a load with rd≠0 through the WB cycle inclusive. `pend_rd`=latched rd; 0 when `pend_valid`=0.
- Same-cycle collision with a primary-port write to the same register is resolved in the register file: the primary port wins. The hazard unit must use `pend_*` to prevent younger writes to a pending rd.

## Timing
- Reset values: `mem_req`, `mem_we`, `rdmau_en`, `misalign`, `pend_valid` = 0; `mem_addr`, `mem_wdata`, `data_mau_in` = 0; `mem_be`, `rdmau`, `pend_rd` = 0; state IDLE.
- `req_ready` is decoded from state, so it is 1 once reset deasserts.
- Accept at cycle N → `mem_req`=1 at N+1.
- `mem_ack` high at cycle M (M≥N+1; zero-wait ack allowed):
  - `mem_req`=0 at M+1.
  - load: `rdmau_en` pulse at M+1 and `req_ready`=1 at M+2 (minimum load latency N→N+2).
  - store: `req_ready`=1 at M+1.
- `mem_ack` outside BUS is ignored.
- `req_valid` while not ready is ignored and not queued.
- Misaligned or illegal request at N: `misalign`=1 at N+1, `req_ready` stays 1.
- `reset` low mid-transaction: all registers clear immediately (asynchronous) and `mem_req` drops. The outstanding bus transfer is abandoned; no writeback or pulse occurs.

## Structure
- Shared package `rv_pkg`: funct3 constants (F3_B/H/W/BU/HU), `mau_state_t` enum {IDLE, BUS, WB}.
- Sub-module `mau_align`: purely combinational store-lane replication/byte-enable generation and load extraction/extension. Top-level holds the FSM and registers.

## Test plan
- LW addr 0x100, rd=5, ack after 2 wait cycles, rdata 0xDEADBEEF → `mem_addr`=0x100, `mem_be`=1111; one `rdmau_en` pulse, `rdmau`=5, `data_mau_in`=0xDEADBEEF; `pend_valid` high through the WB cycle.
- LB addr 0x103, rdata 0x80112233 → `data_mau_in`=0xFFFFFF80; LBU same → 0x00000080; LH addr 0x102 → 0xFFFF8011.
- SH addr 0x22, wdata 0x0000ABCD → `mem_addr`=0x20, `mem_wdata`=0xABCDABCD, `mem_be`=1100, `mem_we`=1; no `rdmau_en`; ready at ack+1.
- LW addr 0x102 → `misalign` pulse next cycle, no `mem_req`, `req_ready` stays 1; funct3=111 load → same.
- LW rd=0 with zero-wait ack → `mem_req` for one cycle, `rdmau_en` never 1, `pend_valid` never 1.
- `reset` low while `mem_req`=1 → `mem_req`=0 without a clock edge. After release, `req_ready`=1 and a late `mem_ack` produces no writeback.
